// File: rtl/adder_seq_ctrl_pkg.sv
// rtl/adder_seq_ctrl_pkg.sv - shared state encoding and word-slice helper for sequenced ALU blocks
`ifndef ADDER_SEQ_CTRL_WORD_SLICE
`define ADDER_SEQ_CTRL_WORD_SLICE
// Selects WIDTH-bit word number idx of a packed vector; word 0 is the least significant.
`define ASC_WORD(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package adder_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational WIDTH-bit adder with carry in and carry out
module adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    output logic [WIDTH-1:0] out,
    output logic             co
);

    logic [WIDTH:0] w_total;

    assign w_total = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, ci};
    assign out     = w_total[WIDTH-1:0];
    assign co      = w_total[WIDTH];

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - word-serial add/subtract sequencer around a narrow adder
// Processes one WIDTH-bit word per cycle, least significant word first.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [WIDTH*WORDS-1:0] op_a,
    input  logic [WIDTH*WORDS-1:0] op_b,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   carry_out,
    output logic                   overflow
);

    localparam int N    = WIDTH * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_out;
    logic             w_co;
    logic             w_accept;
    logic             w_last;

    assign w_a = `ASC_WORD(r_a, r_idx, WIDTH);
    assign w_b = `ASC_WORD(r_b, r_idx, WIDTH);

    adder #(.WIDTH(WIDTH)) u_adder (
        .A   (w_a),
        .B   (w_b),
        .ci  (r_carry),
        .out (w_out),
        .co  (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_last = (r_idx == LAST_IDX);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at accept and the carry seeded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_RUN) begin
            `ASC_WORD(r_sum, r_idx, WIDTH) <= w_out;
            r_carry <= w_co;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_carry_out <= w_co;
                r_overflow  <= (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_out[WIDTH-1] != w_a[WIDTH-1]);
            end
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
